// File: rtl/melody_pkg.sv
// Shared constants for the melody sequencer: note codes, 12 MHz divider counts,
// FSM encoding and ROM word layout.
package melody_pkg;

    localparam int ROM_W = 7;

    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_G4   = 4'd1;
    localparam logic [3:0] NOTE_A4   = 4'd2;
    localparam logic [3:0] NOTE_B4   = 4'd3;
    localparam logic [3:0] NOTE_C5   = 4'd4;
    localparam logic [3:0] NOTE_D5   = 4'd5;
    localparam logic [3:0] NOTE_E5   = 4'd6;
    localparam logic [3:0] NOTE_F5   = 4'd7;
    localparam logic [3:0] NOTE_G5   = 4'd8;

    // Full-period clk counts for each pitch at a 12 MHz system clock
    localparam logic [15:0] DIV_G4 = 16'd30612;
    localparam logic [15:0] DIV_A4 = 16'd27273;
    localparam logic [15:0] DIV_B4 = 16'd24297;
    localparam logic [15:0] DIV_C5 = 16'd22933;
    localparam logic [15:0] DIV_D5 = 16'd20431;
    localparam logic [15:0] DIV_E5 = 16'd18202;
    localparam logic [15:0] DIV_F5 = 16'd17181;
    localparam logic [15:0] DIV_G5 = 16'd15306;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/melody_rom.sv
// Song table: 5-bit index to {note[3:0], dur[2:0]}. Entries past the song are
// silent one-beat rests.
module melody_rom
    import melody_pkg::*;
(
    input  logic [4:0]       idx,
    output logic [ROM_W-1:0] word
);

    always_comb begin
        word = '0;
        case (idx)
            5'd0:  word = {NOTE_G4, 3'd1};
            5'd1:  word = {NOTE_G4, 3'd1};
            5'd2:  word = {NOTE_A4, 3'd2};
            5'd3:  word = {NOTE_G4, 3'd2};
            5'd4:  word = {NOTE_C5, 3'd2};
            5'd5:  word = {NOTE_B4, 3'd4};
            5'd6:  word = {NOTE_G4, 3'd1};
            5'd7:  word = {NOTE_G4, 3'd1};
            5'd8:  word = {NOTE_A4, 3'd2};
            5'd9:  word = {NOTE_G4, 3'd2};
            5'd10: word = {NOTE_D5, 3'd2};
            5'd11: word = {NOTE_C5, 3'd4};
            5'd12: word = {NOTE_G4, 3'd1};
            5'd13: word = {NOTE_G4, 3'd1};
            5'd14: word = {NOTE_G5, 3'd2};
            5'd15: word = {NOTE_E5, 3'd2};
            5'd16: word = {NOTE_C5, 3'd2};
            5'd17: word = {NOTE_B4, 3'd2};
            5'd18: word = {NOTE_A4, 3'd4};
            5'd19: word = {NOTE_F5, 3'd1};
            5'd20: word = {NOTE_F5, 3'd1};
            5'd21: word = {NOTE_E5, 3'd2};
            5'd22: word = {NOTE_C5, 3'd2};
            5'd23: word = {NOTE_D5, 3'd2};
            5'd24: word = {NOTE_C5, 3'd4};
            default: word = {NOTE_REST, 3'd1};
        endcase
    end

endmodule

// File: rtl/melody_sequencer.sv
// Steps through the song ROM, one beat per rising edge of beat_clk, driving the
// tone divider count with an optional silent gap between notes.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int LEN       = 25,
    parameter int GAP_BEATS = 1,
    parameter int LOOP      = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        beat_clk,
    output logic [15:0] tone_div,
    output logic        tone_en,
    output logic [4:0]  note_idx,
    output logic        busy,
    output logic        done
);

    localparam int GAP_W = 8;

    state_t             state;
    logic               beat_q;
    logic               beat_edge;
    logic [2:0]         beats_left;
    logic [GAP_W-1:0]   gap_left;
    logic               last_note;
    logic [4:0]         adv_idx;
    logic [4:0]         rom_addr;
    logic [ROM_W-1:0]   rom_word;
    logic [3:0]         rom_note;
    logic [2:0]         rom_beats;
    logic [15:0]        rom_div;
    logic               rom_tone;
    logic               advance;

    function automatic logic [15:0] note_count(input logic [3:0] code);
        case (code)
            NOTE_G4: note_count = DIV_G4;
            NOTE_A4: note_count = DIV_A4;
            NOTE_B4: note_count = DIV_B4;
            NOTE_C5: note_count = DIV_C5;
            NOTE_D5: note_count = DIV_D5;
            NOTE_E5: note_count = DIV_E5;
            NOTE_F5: note_count = DIV_F5;
            NOTE_G5: note_count = DIV_G5;
            default: note_count = 16'd0;
        endcase
    endfunction

    assign beat_edge = beat_clk & ~beat_q;
    assign last_note = (note_idx >= 5'(LEN - 1));
    assign adv_idx   = last_note ? 5'd0 : note_idx + 5'd1;

    // The single ROM port serves both the first note (from IDLE) and the next note
    assign rom_addr  = (state == ST_IDLE) ? 5'd0 : adv_idx;

    melody_rom u_rom (
        .idx  (rom_addr),
        .word (rom_word)
    );

    assign rom_note  = rom_word[6:3];
    assign rom_beats = (rom_word[2:0] == 3'd0) ? 3'd1 : rom_word[2:0];
    assign rom_div   = note_count(rom_note);
    assign rom_tone  = (rom_div != 16'd0);

    assign advance = beat_edge &&
                     (((state == ST_PLAY) && (beats_left <= 3'd1) && (GAP_BEATS == 0)) ||
                      ((state == ST_GAP) && (gap_left <= GAP_W'(1))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            beat_q     <= 1'b1;
            beats_left <= 3'd0;
            gap_left   <= '0;
            tone_div   <= 16'd0;
            tone_en    <= 1'b0;
            note_idx   <= 5'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            beat_q <= beat_clk;
            done   <= 1'b0;
            if (stop) begin
                state    <= ST_IDLE;
                tone_en  <= 1'b0;
                tone_div <= 16'd0;
                busy     <= 1'b0;
            end else if (advance) begin
                if (!last_note || (LOOP != 0)) begin
                    state      <= ST_PLAY;
                    note_idx   <= adv_idx;
                    beats_left <= rom_beats;
                    tone_div   <= rom_div;
                    tone_en    <= rom_tone;
                end else begin
                    state    <= ST_IDLE;
                    tone_en  <= 1'b0;
                    tone_div <= 16'd0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        // A beat edge coinciding with start is not counted
                        if (start) begin
                            state      <= ST_PLAY;
                            note_idx   <= 5'd0;
                            beats_left <= rom_beats;
                            tone_div   <= rom_div;
                            tone_en    <= rom_tone;
                            busy       <= 1'b1;
                        end
                    end
                    ST_PLAY: begin
                        if (beat_edge) begin
                            if (beats_left <= 3'd1) begin
                                state    <= ST_GAP;
                                gap_left <= GAP_W'(GAP_BEATS);
                                tone_en  <= 1'b0;
                            end else begin
                                beats_left <= beats_left - 3'd1;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (beat_edge) begin
                            gap_left <= gap_left - GAP_W'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
